// File: rtl/byte_mem_arbiter_pkg.sv
// Shared encodings for the byte-wide memory arbiter: transfer sizes, the UART
// address window and FSM states.
package byte_mem_arbiter_pkg;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
   localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

   // addr[17:16] of the UART window; writes there wait on io_buffer_full
   localparam logic [1:0] IO_ADDR_HI = 2'b11;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StIoWait = 2'd1,
      StXfer   = 2'd2
   } arb_state_e;

   // Byte count for a size code; code 3 is treated as a word.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         MEM_SIZE_BYTE: size_bytes = 3'd1;
         MEM_SIZE_HALF: size_bytes = 3'd2;
         default:       size_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/byte_mem_arbiter_if.sv
// Channel request bus plus byte-wide memory bus of the arbiter.
// master: the arbiter; slave: clients and memory/UART side.
interface byte_mem_arbiter_if #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned ADDR_W = 32
);
   logic [NUM_CH-1:0]        req_in;
   logic [NUM_CH-1:0]        we_in;
   logic [2*NUM_CH-1:0]      size_in;
   logic [ADDR_W*NUM_CH-1:0] addr_in;
   logic [32*NUM_CH-1:0]     wdata_in;
   logic [NUM_CH-1:0]        kill_in;
   logic [NUM_CH-1:0]        done_out;
   logic [31:0]              rdata_out;
   logic                     busy_out;
   logic [7:0]               mem_din;
   logic [7:0]               mem_dout;
   logic [31:0]              mem_a;
   logic                     mem_wr;
   logic                     io_buffer_full;

   modport master (
      input  req_in, we_in, size_in, addr_in, wdata_in, kill_in, mem_din, io_buffer_full,
      output done_out, rdata_out, busy_out, mem_dout, mem_a, mem_wr
   );

   modport slave (
      output req_in, we_in, size_in, addr_in, wdata_in, kill_in, mem_din, io_buffer_full,
      input  done_out, rdata_out, busy_out, mem_dout, mem_a, mem_wr
   );

endinterface

// File: rtl/byte_mem_arbiter_mem_grant_sel.sv
// Combinational channel grant: one-hot grant plus index among requesting,
// non-killed channels. BYTE_MEM_ARB_RR_EN selects round-robin starting after
// ptr; otherwise fixed priority with the lowest index winning.
module mem_grant_sel #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned CH_W   = 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [NUM_CH-1:0] kill,
   input  logic [CH_W-1:0]   ptr,
   output logic [NUM_CH-1:0] gnt_oh,
   output logic [CH_W-1:0]   gnt_idx,
   output logic              gnt_any
);

   logic [NUM_CH-1:0] elig;
   assign elig = req & ~kill;

`ifdef BYTE_MEM_ARB_RR_EN
   logic [CH_W-1:0] start;
   assign start = (ptr == CH_W'(NUM_CH - 1)) ? '0 : ptr + 1'b1;

   // Search the rotation that begins at start; loops unroll to constant indices.
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int unsigned s = 0; s < NUM_CH; s++) begin
         if (start == CH_W'(s)) begin
            for (int unsigned o = 0; o < NUM_CH; o++) begin
               if (!gnt_any && elig[(s + o) % NUM_CH]) begin
                  gnt_any                   = 1'b1;
                  gnt_idx                   = CH_W'((s + o) % NUM_CH);
                  gnt_oh[(s + o) % NUM_CH]  = 1'b1;
               end
            end
         end
      end
   end
`else
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   // Lowest eligible index wins.
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (!gnt_any && elig[i]) begin
            gnt_any   = 1'b1;
            gnt_idx   = CH_W'(i);
            gnt_oh[i] = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/byte_mem_arbiter.sv
// N-channel front end to the byte-wide RAM/UART bus. Serialises 1/2/4-byte
// transfers, waits on UART back-pressure, freezes on rdy_in low and aborts
// killed reads. BYTE_MEM_ARB_RR_EN enables round-robin grant (adds a pointer).
module byte_mem_arbiter
   import byte_mem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned ADDR_W = 32
) (
   input logic               clk_in,
   input logic               rst_in,
   input logic               rdy_in,
   byte_mem_arbiter_if.master bus
);

   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   arb_state_e        state_q, state_d;
   logic [NUM_CH-1:0] ch_oh_q, ch_oh_d;
   logic              we_q, we_d;
   logic [2:0]        n_q, n_d;
   logic [2:0]        k_q, k_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rbuf_q, rbuf_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [NUM_CH-1:0] done_q, done_d;
   logic              stalled_q;
   logic [7:0]        stall_byte_q;
   logic [7:0]        byte_in;

   logic [NUM_CH-1:0] gnt_oh;
   logic [CH_W-1:0]   gnt_idx;
   logic              gnt_any;
   logic [CH_W-1:0]   ptr;

   logic              sel_we;
   logic [1:0]        sel_size;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;

`ifdef BYTE_MEM_ARB_RR_EN
   logic [CH_W-1:0] ptr_q;

   // Remember the last granted channel so the next search starts after it.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         ptr_q <= '0;
      end else if (rdy_in && state_q == StIdle && gnt_any) begin
         ptr_q <= gnt_idx;
      end
   end
   assign ptr = ptr_q;
`else
   assign ptr = '0;
`endif

   mem_grant_sel #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_grant_sel (
      .req     (bus.req_in),
      .kill    (bus.kill_in),
      .ptr     (ptr),
      .gnt_oh  (gnt_oh),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // Pick the granted channel's request fields.
   always_comb begin
      sel_we    = 1'b0;
      sel_size  = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (gnt_idx == CH_W'(i)) begin
            sel_we    = bus.we_in[i];
            sel_size  = bus.size_in[2*i +: 2];
            sel_addr  = bus.addr_in[ADDR_W*i +: ADDR_W];
            sel_wdata = bus.wdata_in[32*i +: 32];
         end
      end
   end

   // After a stall, mem_din has moved on; use the byte saved on the first low cycle.
   assign byte_in = stalled_q ? stall_byte_q : bus.mem_din;

   // Next-state: grant, UART wait, byte serialisation and kill.
   always_comb begin
      state_d = state_q;
      ch_oh_d = ch_oh_q;
      we_d    = we_q;
      n_d     = n_q;
      k_d     = k_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rbuf_d  = rbuf_q;
      rdata_d = rdata_q;
      done_d  = '0;
      unique case (state_q)
         StIdle: begin
            if (gnt_any) begin
               ch_oh_d = gnt_oh;
               we_d    = sel_we;
               n_d     = size_bytes(sel_size);
               k_d     = '0;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               rbuf_d  = '0;
               if (sel_we && sel_addr[17:16] == IO_ADDR_HI && bus.io_buffer_full) begin
                  state_d = StIoWait;
               end else begin
                  state_d = StXfer;
               end
            end
         end
         StIoWait: begin
            if (!bus.io_buffer_full) state_d = StXfer;
         end
         StXfer: begin
            if (we_q) begin
               // Started writes always complete; kill is ignored here.
               if (k_q == n_q - 3'd1) begin
                  done_d  = ch_oh_q;
                  state_d = StIdle;
               end else begin
                  k_d = k_q + 3'd1;
               end
            end else if (|(bus.kill_in & ch_oh_q)) begin
               state_d = StIdle;
            end else begin
               if (k_q != 3'd0) rbuf_d[{k_q[1:0] - 2'd1, 3'b000} +: 8] = byte_in;
               if (k_q == n_q) begin
                  rdata_d = rbuf_d;
                  done_d  = ch_oh_q;
                  state_d = StIdle;
               end else begin
                  k_d = k_q + 3'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Main state register; everything holds while rdy_in is low.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q <= StIdle;
         ch_oh_q <= '0;
         we_q    <= 1'b0;
         n_q     <= '0;
         k_q     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rbuf_q  <= '0;
         rdata_q <= '0;
         done_q  <= '0;
      end else if (rdy_in) begin
         state_q <= state_d;
         ch_oh_q <= ch_oh_d;
         we_q    <= we_d;
         n_q     <= n_d;
         k_q     <= k_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rbuf_q  <= rbuf_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
      end
   end

   // Stall tracking keeps running while rdy_in is low.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         stalled_q    <= 1'b0;
         stall_byte_q <= '0;
      end else begin
         stalled_q <= !rdy_in;
         if (!rdy_in && !stalled_q) stall_byte_q <= bus.mem_din;
      end
   end

   // Bus drive: only in XFER with bytes left; the final read-capture cycle idles the bus.
   always_comb begin
      bus.mem_a    = '0;
      bus.mem_dout = '0;
      bus.mem_wr   = 1'b0;
      if (state_q == StXfer && k_q < n_q) begin
         bus.mem_a = 32'(addr_q + ADDR_W'(k_q));
         if (we_q) begin
            bus.mem_dout = wdata_q[{k_q[1:0], 3'b000} +: 8];
            bus.mem_wr   = rdy_in;
         end
      end
   end

   assign bus.done_out  = done_q;
   assign bus.rdata_out = rdata_q;
   assign bus.busy_out  = (state_q != StIdle);

endmodule

// File: tb/tb_byte_mem_arbiter.sv
// Directed bench for byte_mem_arbiter with a queue-based scoreboard for
// completions and memory writes.
module tb_byte_mem_arbiter;

   logic clk_in;
   logic rst_in;
   logic rdy_in;
   int   cyc;
   int   total;
   int   bad;
   logic mon_en;

   byte_mem_arbiter_if #(.NUM_CH(2), .ADDR_W(32)) bus ();

   byte_mem_arbiter #(
      .NUM_CH (2),
      .ADDR_W (32)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .bus    (bus)
   );

   typedef struct {
      logic [1:0]  ch;
      logic [31:0] rdata;
      logic        rd;
      int          cyc;
   } done_exp_t;

   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
      int          cyc;
   } wr_exp_t;

   done_exp_t dq[$];
   wr_exp_t   wq[$];
   logic [7:0] wmem [int];

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   function automatic logic [7:0] init_byte(input int a);
      case (a)
         'h10: init_byte = 8'h11;
         'h11: init_byte = 8'h22;
         'h12: init_byte = 8'h33;
         'h13: init_byte = 8'h44;
         'h20: init_byte = 8'h5A;
         'h21: init_byte = 8'h6B;
         'h22: init_byte = 8'h7C;
         'h23: init_byte = 8'h8D;
         'h40: init_byte = 8'hA0;
         'h41: init_byte = 8'hB1;
         'h60: init_byte = 8'hC6;
         default: init_byte = 8'h00;
      endcase
   endfunction

   // Memory model: registered read of last cycle's address, writes on mem_wr.
   always @(posedge clk_in) begin
      int a;
      a = int'(bus.mem_a[17:0]);
      if (bus.mem_wr) wmem[a] = bus.mem_dout;
      bus.mem_din <= wmem.exists(a) ? wmem[a] : init_byte(a);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: completions and memory writes.
   always @(negedge clk_in) begin
      if (mon_en) begin
         if (bus.done_out !== 2'b00) begin
            if (dq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got %0b expected none (cycle %0d)",
                        bus.done_out, cyc);
            end else begin
               done_exp_t e;
               e = dq.pop_front();
               chk("done_ch", 32'(bus.done_out), 32'(e.ch));
               chk("done_cycle", cyc, e.cyc);
               if (e.rd) chk("rdata", bus.rdata_out, e.rdata);
            end
         end
         if (bus.mem_wr !== 1'b0) begin
            if (wq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got a=%0h expected none (cycle %0d)",
                        bus.mem_a, cyc);
            end else begin
               wr_exp_t w;
               w = wq.pop_front();
               chk("wr_addr", bus.mem_a, w.a);
               chk("wr_data", 32'(bus.mem_dout), 32'(w.d));
               chk("wr_cycle", cyc, w.cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic tick_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic set_ch(input int ch, input logic req, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
      bus.req_in[ch]            = req;
      bus.we_in[ch]             = we;
      bus.size_in[2*ch +: 2]    = sz;
      bus.addr_in[32*ch +: 32]  = a;
      bus.wdata_in[32*ch +: 32] = wd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      cyc    = 0;
      total  = 0;
      bad    = 0;
      mon_en = 1'b0;
      rst_in = 1'b0;
      rdy_in = 1'b1;
      bus.req_in         = '0;
      bus.we_in          = '0;
      bus.size_in        = '0;
      bus.addr_in        = '0;
      bus.wdata_in       = '0;
      bus.kill_in        = '0;
      bus.io_buffer_full = 1'b0;

      // Reset state
      repeat (3) tick();
      @(negedge clk_in);
      chk("rst_done", 32'(bus.done_out), 0);
      chk("rst_rdata", bus.rdata_out, 0);
      chk("rst_mem_a", bus.mem_a, 0);
      chk("rst_mem_wr", 32'(bus.mem_wr), 0);
      chk("rst_mem_dout", 32'(bus.mem_dout), 0);
      chk("rst_busy", 32'(bus.busy_out), 0);
      tick();
      rst_in = 1'b1;
      mon_en = 1'b1;
      tick();

      // Ch1 word read at 0x10
      tick();
      t = cyc;
      set_ch(1, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
      dq.push_back(done_exp_t'{2'b10, 32'h4433_2211, 1'b1, t + 6});
      for (int k = 1; k <= 4; k++) begin
         tick_to(t + k);
         @(negedge clk_in);
         chk("t1_mem_a", bus.mem_a, 32'h10 + 32'(k - 1));
      end
      tick_to(t + 6);
      bus.req_in[1] = 1'b0;
      tick_to(t + 8);

      // Both channels request continuously, three byte reads each
      tick();
      t = cyc;
      set_ch(0, 1'b1, 1'b0, 2'd0, 32'h40, 32'h0);
      set_ch(1, 1'b1, 1'b0, 2'd0, 32'h41, 32'h0);
`ifdef BYTE_MEM_ARB_RR_EN
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) dq.push_back(done_exp_t'{2'b01, 32'hA0, 1'b1, t + 3 + 3*i});
         else            dq.push_back(done_exp_t'{2'b10, 32'hB1, 1'b1, t + 3 + 3*i});
      end
      tick_to(t + 15);
`else
      for (int i = 0; i < 3; i++) dq.push_back(done_exp_t'{2'b01, 32'hA0, 1'b1, t + 3 + 3*i});
      for (int i = 0; i < 3; i++) dq.push_back(done_exp_t'{2'b10, 32'hB1, 1'b1, t + 12 + 3*i});
      tick_to(t + 9);
`endif
      bus.req_in[0] = 1'b0;
      tick_to(t + 18);
      bus.req_in[1] = 1'b0;
      tick_to(t + 20);

      // Byte write to the UART window with io_buffer_full high for 5 cycles
      tick();
      t = cyc;
      bus.io_buffer_full = 1'b1;
      set_ch(0, 1'b1, 1'b1, 2'd0, 32'h3_0000, 32'h41);
      wq.push_back(wr_exp_t'{32'h3_0000, 8'h41, t + 6});
      dq.push_back(done_exp_t'{2'b01, 32'h0, 1'b0, t + 7});
      tick_to(t + 3);
      @(negedge clk_in);
      chk("t3_busy_io_wait", 32'(bus.busy_out), 1);
      chk("t3_mem_wr_io_wait", 32'(bus.mem_wr), 0);
      tick_to(t + 5);
      bus.io_buffer_full = 1'b0;
      tick_to(t + 7);
      bus.req_in[0] = 1'b0;
      bus.we_in[0]  = 1'b0;
      tick_to(t + 9);

      // Word read at 0x20 with rdy_in low for 3 cycles after the second address
      tick();
      t = cyc;
      set_ch(0, 1'b1, 1'b0, 2'd2, 32'h20, 32'h0);
      dq.push_back(done_exp_t'{2'b01, 32'h8D7C_6B5A, 1'b1, t + 9});
      tick_to(t + 3);
      rdy_in = 1'b0;
      @(negedge clk_in);
      chk("t4_mem_a_stall", bus.mem_a, 32'h22);
      tick_to(t + 6);
      rdy_in = 1'b1;
      @(negedge clk_in);
      chk("t4_mem_a_resume", bus.mem_a, 32'h22);
      tick_to(t + 9);
      bus.req_in[0] = 1'b0;
      tick_to(t + 11);

      // Kill ch1 during the 3rd byte; pending ch0 granted at once
      tick();
      t = cyc;
      set_ch(1, 1'b1, 1'b0, 2'd2, 32'h50, 32'h0);
      tick_to(t + 1);
      set_ch(0, 1'b1, 1'b0, 2'd0, 32'h60, 32'h0);
      dq.push_back(done_exp_t'{2'b01, 32'hC6, 1'b1, t + 7});
      tick_to(t + 3);
      bus.kill_in[1] = 1'b1;
      tick_to(t + 4);
      bus.kill_in[1] = 1'b0;
      bus.req_in[1]  = 1'b0;
      @(negedge clk_in);
      chk("t5_idle_busy", 32'(bus.busy_out), 0);
      chk("t5_idle_mem_a", bus.mem_a, 0);
      tick_to(t + 5);
      @(negedge clk_in);
      chk("t5_ch0_mem_a", bus.mem_a, 32'h60);
      tick_to(t + 7);
      bus.req_in[0] = 1'b0;
      tick_to(t + 9);

      // Reset during the 2nd byte of a half write
      tick();
      t = cyc;
      set_ch(0, 1'b1, 1'b1, 2'd1, 32'h70, 32'h0000_BEEF);
      wq.push_back(wr_exp_t'{32'h70, 8'hEF, t + 1});
      wq.push_back(wr_exp_t'{32'h71, 8'hBE, t + 2});
      tick_to(t + 2);
      rst_in = 1'b0;
      tick_to(t + 3);
      rst_in        = 1'b1;
      bus.req_in[0] = 1'b0;
      bus.we_in[0]  = 1'b0;
      @(negedge clk_in);
      chk("t6_mem_wr", 32'(bus.mem_wr), 0);
      chk("t6_mem_a", bus.mem_a, 0);
      chk("t6_mem_dout", 32'(bus.mem_dout), 0);
      chk("t6_busy", 32'(bus.busy_out), 0);
      chk("t6_done", 32'(bus.done_out), 0);
      chk("t6_partial_byte", 32'(wmem.exists('h71) ? wmem['h71] : 8'h00), 32'hBE);
      tick_to(t + 6);

      chk("done_queue_empty", dq.size(), 0);
      chk("write_queue_empty", wq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
